fetch_unit: RTL
===============

# fetch_unit

Parametrised instruction-fetch stage for the pipelined CPU: PC register, PC+step adder, branch redirect mux and IF/ID pipeline register, extended with an external instruction-memory request/ready handshake, stall, flush and a one-entry skid buffer. It sits between the instruction memory and the ID stage. It supplies `o_next_pc` and `o_data` to decode exactly as the previous single-cycle-memory fetch stage did, and adds a valid qualifier.

## Interface
- `ADDR_W`, 32, PC and address width.
- `DATA_W`, 32, instruction width.
- `RESET_PC`, 0, PC value loaded at reset.
- `PC_STEP`, 4, sequential increment (power of two).
- `NOP_WORD`, 0, value driven on `o_data` for a bubble.
- `i_clk` in 1: single clock, rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_pcsrc` in 1: redirect request; PC takes `i_branch_addr`.
- `i_branch_addr` in ADDR_W: redirect target.
- `i_stall` in 1: hold PC and the IF/ID register.
- `i_flush` in 1: turn the IF/ID register into a bubble.
- `o_imem_req` out 1: fetch request.
- `o_imem_addr` out ADDR_W: fetch address (the current PC).
- `i_imem_ready` in 1: `i_imem_rdata` is valid this cycle; same-cycle handshake.
- `i_imem_rdata` in DATA_W: fetched instruction.
- `o_next_pc` out ADDR_W: IF/ID copy of fetch PC + PC_STEP.
- `o_data` out DATA_W: IF/ID instruction.
- `o_valid` out 1: IF/ID holds a real instruction.
- `o_misalign` out 1: misaligned redirect flag (see Configuration).

## Operation
- Two-state FSM, FETCH and HOLD. Reset state is FETCH.
- FETCH:
  - `o_imem_req` = 1 and `o_imem_addr` = PC.
  - A handshake is `o_imem_req & i_imem_ready`.
  - Handshake with `i_stall` = 0: IF/ID loads {PC+PC_STEP, rdata} and sets valid = 1. PC advances to PC+PC_STEP.
  - Handshake with `i_stall` = 1: rdata and PC+PC_STEP go to the skid buffer, then go to HOLD. PC holds.
  - No handshake: PC holds. IF/ID holds if stalled; otherwise it loads a bubble.
- HOLD:
  - `o_imem_req` = 0.
  - When `i_stall` falls, IF/ID loads the skid contents with valid = 1, PC advances to PC+PC_STEP, and the FSM returns to FETCH.
- Redirect (`i_pcsrc` = 1) is taken in any state and regardless of `i_stall`:
  - PC <= `i_branch_addr`.
  - A same-cycle handshake word is discarded.
  - The skid buffer is discarded and the FSM goes to FETCH.
  - IF/ID loads a bubble.
- Flush (`i_flush` = 1): IF/ID loads a bubble (valid 0, `o_data` = NOP_WORD, `o_next_pc` = 0). PC and FSM behave as if `i_stall` = 0.
- Priority: reset > redirect > flush > stall > normal.
- Arithmetic: PC+PC_STEP is modulo 2^ADDR_W. 0xFFFFFFFC + 4 wraps to 0 with no flag.
- The memory may see `o_imem_addr` change while `o_imem_req` stays high without `i_imem_ready`; it must tolerate this.

## Timing
- Reset values:
  - PC = RESET_PC, FSM = FETCH.
  - `o_valid` = 0, `o_data` = NOP_WORD, `o_next_pc` = 0, `o_misalign` = 0.
  - `o_imem_req` = 1 and `o_imem_addr` = RESET_PC while reset is released.
- Latency: an instruction handshaken in cycle N appears on `o_data` with `o_valid` = 1 in cycle N+1. With ready held high, throughput is 1 instruction per cycle.
- Redirect asserted in cycle N:
  - `o_imem_addr` = `i_branch_addr` in cycle N+1.
  - The target instruction appears in IF/ID at N+2 at the earliest.
  - `o_valid` = 0 at N+1.
- Stall release from HOLD: the skid instruction appears the cycle after `i_stall` falls. No memory re-request is made.
- Reset asserted mid-operation: all state clears immediately and asynchronously, and any skid contents are lost.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A redirect with `i_branch_addr` low log2(PC_STEP) bits nonzero clears those bits before loading PC.
  - `o_misalign` pulses 1 for the cycle after the redirect.
- Undefined: the address is loaded verbatim and `o_misalign` is tied 0.

## Test plan
- Reset release with ready held high: `o_imem_addr` reads 0, 4, 8. IF/ID shows {4, I0} then {8, I1} with valid 1 from cycle 1.
- Stall on a handshake at PC 0x10:
  - `o_imem_req` drops for the 3 stall cycles.
  - After release, IF/ID shows {0x14, I(0x10)} once.
  - The next request is to 0x14 with no duplicate or missing word.
- `i_pcsrc` with `i_branch_addr` = 0x100 during a handshake at 0x20: the 0x20 word is dropped, valid is 0 for one cycle, and the next request is 0x100.
- `i_imem_ready` low for 4 cycles: the PC holds and bubbles with valid 0 and `o_data` = NOP_WORD enter IF/ID.
- Redirect to 0x102:
  - With `FETCH_ALIGN_CHECK_EN`, the fetch goes to 0x100 and `o_misalign` pulses once.
  - Without it, the fetch goes to 0x102 and `o_misalign` stays 0.
- PC 0xFFFFFFFC wraps: the next fetch is 0, and reset asserted mid-HOLD returns all outputs to their reset values.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, redirect mux, imem request/ready handshake,
// one-entry skid buffer and IF/ID register. Define FETCH_ALIGN_CHECK_EN to align redirects.
`timescale 1ns/1ps

module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pcsrc,
  input  logic [ADDR_W-1:0] i_branch_addr,
  input  logic              i_stall,
  input  logic              i_flush,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_ready,
  input  logic [DATA_W-1:0] i_imem_rdata,
  output logic [ADDR_W-1:0] o_next_pc,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_misalign
);

  typedef enum logic {S_FETCH, S_HOLD} state_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] next_pc;
    logic [DATA_W-1:0] data;
  } ifid_t;

  typedef struct packed {
    logic [ADDR_W-1:0] next_pc;
    logic [DATA_W-1:0] data;
  } skid_t;

  localparam logic [ADDR_W-1:0] STEP        = ADDR_W'(PC_STEP);
  localparam ifid_t             IFID_BUBBLE = '{valid: 1'b0, next_pc: '0, data: NOP_WORD};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] redirect_pc;
  skid_t             skid_q, skid_d;
  ifid_t             ifid_q, ifid_d;
  logic              handshake;
  logic              stall_eff;

  assign o_imem_req  = (state_q == S_FETCH);
  assign o_imem_addr = pc_q;
  assign handshake   = o_imem_req & i_imem_ready;
  // A flush releases the stall for PC and FSM purposes; only IF/ID is bubbled.
  assign stall_eff   = i_stall & ~i_flush;
  assign pc_inc      = pc_q + STEP;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(PC_STEP - 1);

  logic misalign_q;

  assign redirect_pc = i_branch_addr & ~LOW_MASK;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) misalign_q <= 1'b0;
    else          misalign_q <= i_pcsrc & (|(i_branch_addr & LOW_MASK));
  end

  assign o_misalign = misalign_q;
`else
  assign redirect_pc = i_branch_addr;
  assign o_misalign  = 1'b0;
`endif

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path infers a latch.
    state_d = state_q;
    pc_d    = pc_q;
    skid_d  = skid_q;
    ifid_d  = ifid_q;

    if (i_pcsrc) begin
      pc_d    = redirect_pc;
      state_d = S_FETCH;
      ifid_d  = IFID_BUBBLE;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (handshake && stall_eff) begin
            skid_d  = '{next_pc: pc_inc, data: i_imem_rdata};
            state_d = S_HOLD;
          end else if (handshake) begin
            pc_d   = pc_inc;
            ifid_d = i_flush ? IFID_BUBBLE
                             : '{valid: 1'b1, next_pc: pc_inc, data: i_imem_rdata};
          end else if (i_flush || !i_stall) begin
            ifid_d = IFID_BUBBLE;
          end
        end
        S_HOLD: begin
          // The skid word was fetched from the held PC, so releasing advances it.
          if (!stall_eff) begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
            ifid_d  = i_flush ? IFID_BUBBLE
                              : '{valid: 1'b1, next_pc: skid_q.next_pc, data: skid_q.data};
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!i_rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      skid_q  <= '0;
      ifid_q  <= IFID_BUBBLE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      skid_q  <= skid_d;
      ifid_q  <= ifid_d;
    end
  end

  assign o_valid   = ifid_q.valid;
  assign o_next_pc = ifid_q.next_pc;
  assign o_data    = ifid_q.data;

endmodule
